// File: rtl/cur_mb_pp_pkg.sv
// ---------------------------------------------------------------------------
// cur_mb_pp_pkg
// Shared encoder definitions for the current-macroblock loader: sample depth,
// macroblock geometry, loader FSM state encodings and a beat-count helper.
// No ports (package).
// ---------------------------------------------------------------------------
package cur_mb_pp_pkg;

  // Default bits per sample used by the encoder datapath.
  localparam int DEF_BIT_DEPTH = 8;

  // Macroblock geometry (16x16 luma, two 8x8 chroma planes in 4:2:0).
  localparam int MB_LUMA_PIX   = 256;
  localparam int MB_CHROMA_PIX = 64;

  // Loader FSM encodings.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LOAD_Y = 2'd1;
  localparam logic [1:0] ST_LOAD_C = 2'd2;

  // Width of a counter spanning all luma + chroma beats of one macroblock.
  function automatic int beat_cnt_width(input int pix_per_beat);
    return $clog2((MB_LUMA_PIX + 2 * MB_CHROMA_PIX) / pix_per_beat);
  endfunction

endpackage

// File: rtl/cur_mb_bank.sv
// ---------------------------------------------------------------------------
// cur_mb_bank
// One storage bank of a current macroblock: 256 luma + 64 U + 64 V samples.
// Written one beat at a time; the beat index selects which group of samples
// the beat lands in. A mono-fill strobe sets both chroma planes to mid-grey.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset (clears all samples)
//   wr_en           write the current beat
//   wr_chroma       0 = beat is luma, 1 = beat is interleaved U/V pairs
//   wr_idx          beat index within the luma or chroma phase
//   wr_data         beat pixels, first pixel in the MSBs
//   mono_fill       set every U/V sample to 2^(BIT_DEPTH-1)
//   luma, u, v      flat sample vectors, pixel j at [(j+1)*BD-1 : j*BD]
// ---------------------------------------------------------------------------
module cur_mb_bank
  import cur_mb_pp_pkg::*;
#(
  parameter int PIX_PER_BEAT = 8,
  parameter int BIT_DEPTH    = DEF_BIT_DEPTH,
  parameter int IDX_W        = 6
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  input  logic                                wr_chroma,
  input  logic [IDX_W-1:0]                    wr_idx,
  input  logic [PIX_PER_BEAT*BIT_DEPTH-1:0]   wr_data,
  input  logic                                mono_fill,
  output logic [MB_LUMA_PIX*BIT_DEPTH-1:0]    luma,
  output logic [MB_CHROMA_PIX*BIT_DEPTH-1:0]  u,
  output logic [MB_CHROMA_PIX*BIT_DEPTH-1:0]  v
);

  localparam int HALF = PIX_PER_BEAT / 2;
  localparam logic [BIT_DEPTH-1:0] MID_GREY = {1'b1, {(BIT_DEPTH-1){1'b0}}};

  // Split the beat into pixels; slot 0 is the first pixel (MSBs).
  logic [BIT_DEPTH-1:0] wr_pix [PIX_PER_BEAT];

  for (genvar g = 0; g < PIX_PER_BEAT; g++) begin : g_split
    assign wr_pix[g] = wr_data[(PIX_PER_BEAT-g)*BIT_DEPTH-1 -: BIT_DEPTH];
  end

  // Each luma sample j belongs to beat j/P, slot j%P. Decoding per sample
  // keeps every select constant, so there is no variable-index write logic.
  for (genvar j = 0; j < MB_LUMA_PIX; j++) begin : g_luma
    logic [BIT_DEPTH-1:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q <= '0;
      end else if (wr_en && !wr_chroma &&
                   wr_idx == IDX_W'(j / PIX_PER_BEAT)) begin
        q <= wr_pix[j % PIX_PER_BEAT];
      end
    end

    assign luma[j*BIT_DEPTH +: BIT_DEPTH] = q;
  end

  // Chroma sample c belongs to beat c/HALF; its U is at slot 2*(c%HALF) and
  // its V right after it. Mono-fill overrides any write (they never coincide).
  for (genvar c = 0; c < MB_CHROMA_PIX; c++) begin : g_chroma
    logic [BIT_DEPTH-1:0] uq;
    logic [BIT_DEPTH-1:0] vq;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        uq <= '0;
        vq <= '0;
      end else if (mono_fill) begin
        uq <= MID_GREY;
        vq <= MID_GREY;
      end else if (wr_en && wr_chroma &&
                   wr_idx == IDX_W'(c / HALF)) begin
        uq <= wr_pix[2 * (c % HALF)];
        vq <= wr_pix[2 * (c % HALF) + 1];
      end
    end

    assign u[c*BIT_DEPTH +: BIT_DEPTH] = uq;
    assign v[c*BIT_DEPTH +: BIT_DEPTH] = vq;
  end

endmodule

// File: rtl/cur_mb_pp.sv
// ---------------------------------------------------------------------------
// cur_mb_pp
// Double-buffered current-macroblock loader for the intra encoder. Raw
// macroblocks stream in over a ready/valid pixel bus into the load bank while
// the intra pipeline reads the other (output) bank. mb_switch publishes the
// most recently completed macroblock.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   chroma_en         1 = 4:2:0 (luma then chroma), 0 = luma only
//   load_start        one-cycle request to load a macroblock
//   load_busy         a load is pending or in progress
//   load_done         one-cycle pulse when the load bank is complete
//   pvalid_i/pinc_o   beat valid / ready; beat accepted when both high
//   pdata_i           PIX_PER_BEAT pixels, first pixel in the MSBs
//   mb_switch         publish the loaded bank to the output side
//   switch_err        one-cycle pulse: switch with no full load bank
//   out_valid         output bank holds a valid macroblock
//   intra_cur_*       output bank samples, raster order
// ---------------------------------------------------------------------------
module cur_mb_pp
  import cur_mb_pp_pkg::*;
#(
  parameter int PIX_PER_BEAT = 8,
  parameter int BIT_DEPTH    = DEF_BIT_DEPTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                chroma_en,
  input  logic                                load_start,
  output logic                                load_busy,
  output logic                                load_done,
  input  logic                                pvalid_i,
  output logic                                pinc_o,
  input  logic [PIX_PER_BEAT*BIT_DEPTH-1:0]   pdata_i,
  input  logic                                mb_switch,
  output logic                                switch_err,
  output logic                                out_valid,
  output logic [MB_LUMA_PIX*BIT_DEPTH-1:0]    intra_cur_luma,
  output logic [MB_CHROMA_PIX*BIT_DEPTH-1:0]  intra_cur_u,
  output logic [MB_CHROMA_PIX*BIT_DEPTH-1:0]  intra_cur_v
);

  localparam int LY = MB_LUMA_PIX / PIX_PER_BEAT;
  localparam int LC = (2 * MB_CHROMA_PIX) / PIX_PER_BEAT;
  localparam int CW = beat_cnt_width(PIX_PER_BEAT);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          pending;
  logic          chroma_q;
  logic          rd_sel;
  logic [1:0]    full;

  logic          ld_bank;
  logic          beat_acc;
  logic          start_acc;
  logic          last_y;
  logic          last_c;
  logic          complete;
  logic          sw_ok;
  logic [CW-1:0] wr_idx;
  logic          wr_chroma;
  logic          mono_fill;

  // The load bank is always the one not being read.
  assign ld_bank   = ~rd_sel;
  assign beat_acc  = pvalid_i && pinc_o;
  assign start_acc = (state == ST_IDLE) && pending && !full[ld_bank];
  assign last_y    = (state == ST_LOAD_Y) && beat_acc && (cnt == CW'(LY - 1));
  assign last_c    = (state == ST_LOAD_C) && beat_acc && (cnt == CW'(LY + LC - 1));
  assign complete  = (last_y && !chroma_q) || last_c;
  // Switch looks only at the registered full flag, so a switch coinciding
  // with the final beat is refused.
  assign sw_ok     = mb_switch && full[ld_bank];

  assign load_busy = pending || (state != ST_IDLE);

  // The beat counter runs across both phases; chroma beats are re-based so
  // the bank sees a beat index relative to the chroma phase.
  assign wr_chroma = (state == ST_LOAD_C);
  assign wr_idx    = wr_chroma ? (cnt - CW'(LY)) : cnt;
  assign mono_fill = last_y && !chroma_q;

  // Loader FSM. A single pending slot remembers one load_start request at
  // any time, including during a load; a load begins only once the load
  // bank has been freed. pinc_o is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      pending   <= 1'b0;
      chroma_q  <= 1'b0;
      pinc_o    <= 1'b0;
      load_done <= 1'b0;
    end else begin
      pending   <= load_start || (pending && !start_acc);
      load_done <= complete;
      case (state)
        ST_IDLE: begin
          if (start_acc) begin
            state    <= ST_LOAD_Y;
            chroma_q <= chroma_en;
            cnt      <= '0;
            pinc_o   <= 1'b1;
          end
        end
        ST_LOAD_Y: begin
          if (beat_acc) begin
            if (last_y && !chroma_q) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              pinc_o <= 1'b0;
            end else begin
              if (last_y) begin
                state <= ST_LOAD_C;
              end
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_LOAD_C: begin
          if (beat_acc) begin
            if (last_c) begin
              state  <= ST_IDLE;
              cnt    <= '0;
              pinc_o <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          pinc_o <= 1'b0;
        end
      endcase
    end
  end

  // Bank bookkeeping: completion marks the load bank full; an accepted
  // switch flips the read side and frees the bank it just stopped reading.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_sel     <= 1'b0;
      full       <= 2'b00;
      out_valid  <= 1'b0;
      switch_err <= 1'b0;
    end else begin
      switch_err <= mb_switch && !full[ld_bank];
      if (complete) begin
        full[ld_bank] <= 1'b1;
      end
      if (sw_ok) begin
        rd_sel       <= ~rd_sel;
        full[rd_sel] <= 1'b0;
        out_valid    <= 1'b1;
      end
    end
  end

  logic [MB_LUMA_PIX*BIT_DEPTH-1:0]   luma0, luma1;
  logic [MB_CHROMA_PIX*BIT_DEPTH-1:0] u0, u1, v0, v1;

  cur_mb_bank #(
    .PIX_PER_BEAT (PIX_PER_BEAT),
    .BIT_DEPTH    (BIT_DEPTH),
    .IDX_W        (CW)
  ) u_bank0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (beat_acc && (ld_bank == 1'b0)),
    .wr_chroma (wr_chroma),
    .wr_idx    (wr_idx),
    .wr_data   (pdata_i),
    .mono_fill (mono_fill && (ld_bank == 1'b0)),
    .luma      (luma0),
    .u         (u0),
    .v         (v0)
  );

  cur_mb_bank #(
    .PIX_PER_BEAT (PIX_PER_BEAT),
    .BIT_DEPTH    (BIT_DEPTH),
    .IDX_W        (CW)
  ) u_bank1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (beat_acc && (ld_bank == 1'b1)),
    .wr_chroma (wr_chroma),
    .wr_idx    (wr_idx),
    .wr_data   (pdata_i),
    .mono_fill (mono_fill && (ld_bank == 1'b1)),
    .luma      (luma1),
    .u         (u1),
    .v         (v1)
  );

  // Outputs come straight from the selected bank's registers; the read bank
  // is never written, so they hold steady until the next accepted switch.
  assign intra_cur_luma = rd_sel ? luma1 : luma0;
  assign intra_cur_u    = rd_sel ? u1    : u0;
  assign intra_cur_v    = rd_sel ? v1    : v0;

endmodule
